// File: rtl/float_adder_arbiter.sv
// Round-robin arbiter that shares one stb/ack float adder among NREQ requesters,
// with one operation in flight and a sticky stall timeout.
module float_adder_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_stb,
  input  logic [32*NREQ-1:0]   i_req_a,
  input  logic [32*NREQ-1:0]   i_req_b,
  output logic [NREQ-1:0]      o_req_ack,
  output logic [31:0]          o_rsp_z,
  output logic [NREQ-1:0]      o_rsp_stb,
  input  logic [NREQ-1:0]      i_rsp_ack,
  output logic [31:0]          o_add_a,
  output logic                 o_add_a_stb,
  input  logic                 i_add_a_ack,
  output logic [31:0]          o_add_b,
  output logic                 o_add_b_stb,
  input  logic                 i_add_b_ack,
  input  logic [31:0]          i_add_z,
  input  logic                 i_add_z_stb,
  output logic                 o_add_z_ack,
  output logic [15:0]          o_op_count,
  output logic                 o_err_timeout
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_Z, S_ACK_Z, S_RESPOND} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_grant;
  logic [NREQ-1:0] r_req_ack;
  logic [31:0]     r_rsp_z;
  logic [NREQ-1:0] r_rsp_stb;
  logic [31:0]     r_add_a;
  logic            r_add_a_stb;
  logic [31:0]     r_add_b;
  logic            r_add_b_stb;
  logic            r_add_z_ack;
  logic [15:0]     r_op_count;
  logic            r_err_timeout;
  logic [SW-1:0]   r_stall;

  logic            w_grant_vld;
  logic [GW-1:0]   w_grant;
  logic [31:0]     w_req_a [NREQ];
  logic [31:0]     w_req_b [NREQ];
  logic            w_a_done;
  logic            w_b_done;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_req_a[i] = i_req_a[32*i +: 32];
      w_req_b[i] = i_req_b[32*i +: 32];
    end
  end

  // Search starts just after the last served requester so every requester gets a turn.
  always_comb begin : grant_search
    int            idx;
    logic [GW-1:0] cand;
    // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
    w_grant_vld = 1'b0;
    w_grant     = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = GW'(idx);
      if (!w_grant_vld && i_req_stb[cand]) begin
        w_grant_vld = 1'b1;
        w_grant     = cand;
      end
    end
  end

  // An operand counts as sent once its stb was dropped or its ack is being sampled now.
  assign w_a_done = !r_add_a_stb || i_add_a_ack;
  assign w_b_done = !r_add_b_stb || i_add_b_ack;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= GW'(NREQ - 1);
      r_grant       <= '0;
      r_req_ack     <= '0;
      r_rsp_z       <= '0;
      r_rsp_stb     <= '0;
      r_add_a       <= '0;
      r_add_a_stb   <= 1'b0;
      r_add_b       <= '0;
      r_add_b_stb   <= 1'b0;
      r_add_z_ack   <= 1'b0;
      r_op_count    <= '0;
      r_err_timeout <= 1'b0;
      r_stall       <= '0;
    end else begin
      r_req_ack <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_grant     <= w_grant;
            r_add_a     <= w_req_a[w_grant];
            r_add_b     <= w_req_b[w_grant];
            r_add_a_stb <= 1'b1;
            r_add_b_stb <= 1'b1;
            r_req_ack   <= NREQ'(1) << w_grant;
            r_stall     <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_add_a_stb && i_add_a_ack) r_add_a_stb <= 1'b0;
          if (r_add_b_stb && i_add_b_ack) r_add_b_stb <= 1'b0;
          if (w_a_done && w_b_done) r_state <= S_WAIT_Z;
        end
        S_WAIT_Z: begin
          if (i_add_z_stb) begin
            r_rsp_z     <= i_add_z;
            r_add_z_ack <= 1'b1;
            r_state     <= S_ACK_Z;
          end
        end
        S_ACK_Z: begin
          r_add_z_ack <= 1'b0;
          r_rsp_stb   <= NREQ'(1) << r_grant;
          r_state     <= S_RESPOND;
        end
        S_RESPOND: begin
          if (i_rsp_ack[r_grant]) begin
            r_ptr      <= r_grant;
            r_op_count <= r_op_count + 16'd1;
            r_rsp_stb  <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Saturating stall counter; the error only flags the stall, the FSM keeps waiting.
      if (r_state == S_ISSUE || r_state == S_WAIT_Z) begin
        if (r_stall != SW'(TIMEOUT)) r_stall <= r_stall + 1'b1;
        if (r_stall >= SW'(TIMEOUT - 1)) r_err_timeout <= 1'b1;
      end
    end
  end

  assign o_req_ack     = r_req_ack;
  assign o_rsp_z       = r_rsp_z;
  assign o_rsp_stb     = r_rsp_stb;
  assign o_add_a       = r_add_a;
  assign o_add_a_stb   = r_add_a_stb;
  assign o_add_b       = r_add_b;
  assign o_add_b_stb   = r_add_b_stb;
  assign o_add_z_ack   = r_add_z_ack;
  assign o_op_count    = r_op_count;
  assign o_err_timeout = r_err_timeout;

endmodule
